// File: rtl/ifu_fetch.sv
// ifu_fetch: instruction fetch front end. Holds the PC, issues word reads
// to a synchronous instruction SRAM (1-cycle read latency), tracks the
// in-flight read, queues returned words in a 2-entry FIFO and presents
// {pc, ins} pairs to decode with a valid/ready handshake. A branch from
// execute flushes all fetched state and issues the target in the same cycle.
//
// Parameters:
//   AW        byte-address width of PC and SRAM address
//   RESET_PC  PC loaded on reset (bits [1:0] must be 0)
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   ins_a, ins_e        SRAM request address / enable (sampled at posedge)
//   ins                 SRAM read data, valid the cycle after a request
//   branch, branch_pc   redirect request and target (bits [1:0] ignored)
//   ifu_vld, ifu_rdy    handshake to decode
//   ifu_pc, ifu_ins     presented instruction (FIFO head)
// Optional feature macro IFU_PERF_EN adds:
//   perf_fetch          count of accepted instructions (wrapping)
//   perf_flush          count of cycles with branch high (wrapping)

module ifu_fetch #(
    parameter int          AW       = 16,
    parameter logic [AW-1:0] RESET_PC = '0
) (
    input  logic          clk,
    input  logic          rst,
    output logic [AW-1:0] ins_a,
    output logic          ins_e,
    input  logic [31:0]   ins,
    input  logic          branch,
    input  logic [AW-1:0] branch_pc,
    output logic          ifu_vld,
    input  logic          ifu_rdy,
    output logic [AW-1:0] ifu_pc,
    output logic [31:0]   ifu_ins
`ifdef IFU_PERF_EN
    ,
    output logic [31:0]   perf_fetch,
    output logic [15:0]   perf_flush
`endif
);

    logic [AW-1:0] pc;
    logic          inf_vld;
    logic [AW-1:0] inf_pc;
    logic          inf_kill;

    logic [AW-1:0] q_pc  [2];
    logic [31:0]   q_ins [2];
    logic [1:0]    cnt;
    logic          rd_ptr;
    logic          wr_ptr;

    logic          pop;
    logic          push;
    logic [2:0]    pending;
    logic          bpc_unused;

    assign bpc_unused = ^branch_pc[1:0];

    assign pop = ifu_vld & ifu_rdy;

    // Words that will occupy the FIFO after this edge if nothing new issues.
    assign pending = {1'b0, cnt} + {2'b00, inf_vld} - {2'b00, pop};

    assign ins_e = !rst & (branch | (pending < 3'd2));
    assign ins_a = branch ? {branch_pc[AW-1:2], 2'b00} : pc;

    // A branch drops the word arriving this cycle; the redirected request
    // lands after the flush, so it never needs killing.
    assign inf_kill = branch;
    assign push     = inf_vld & !inf_kill;

    assign ifu_vld = (cnt != 2'd0);
    assign ifu_pc  = q_pc[rd_ptr];
    assign ifu_ins = q_ins[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc      <= RESET_PC;
            inf_vld <= 1'b0;
            inf_pc  <= '0;
            cnt     <= 2'd0;
            rd_ptr  <= 1'b0;
            wr_ptr  <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                q_pc[i]  <= '0;
                q_ins[i] <= '0;
            end
        end else begin
            if (ins_e) begin
                pc <= ins_a + AW'(4);
            end
            inf_vld <= ins_e;
            inf_pc  <= ins_a;
            if (branch) begin
                cnt    <= 2'd0;
                rd_ptr <= 1'b0;
                wr_ptr <= 1'b0;
            end else begin
                if (push) begin
                    q_pc[wr_ptr]  <= inf_pc;
                    q_ins[wr_ptr] <= ins;
                    wr_ptr        <= ~wr_ptr;
                end
                if (pop) begin
                    rd_ptr <= ~rd_ptr;
                end
                cnt <= cnt + {1'b0, push} - {1'b0, pop};
            end
        end
    end

`ifdef IFU_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_fetch <= '0;
            perf_flush <= '0;
        end else begin
            if (pop) begin
                perf_fetch <= perf_fetch + 32'd1;
            end
            if (branch) begin
                perf_flush <= perf_flush + 16'd1;
            end
        end
    end
`else
    // Performance counters not built.
`endif

endmodule
